i2q2_power_engine: RTL and testbench
====================================

// Module: i2q2_power_engine
// PURPOSE
//   Parametrised successor to the per-channel fixed early/prompt/late I2Q2 stage.
//   Snapshots NUM_TAPS signed I/Q correlator accumulations on accumulation_complete.
//   Streams them one tap per cycle through a single pipelined squarer pair.
//   Adds optional non-coherent integration over noncoh_len accumulation periods, then presents per-tap power.
//   Sits between the subchannel bank and the acquisition/tracking controllers.
// PARAMETERS
//   NUM_TAPS    3   number of correlator taps (>=1); tap 0 = earliest
//   ACC_WIDTH   16  signed width of each I/Q accumulation
//   OUT_WIDTH   32  unsigned width of each per-tap I2Q2 result (>= 2*ACC_WIDTH)
//   SQ_LATENCY  5   pipeline latency of the squarer
//   NC_WIDTH    4   width of noncoh_len
// PORTS
//   clk                    in   1                   system clock
//   global_reset           in   1                   asynchronous, active-high reset
//   noncoh_len             in   NC_WIDTH            periods per non-coherent sum; 0 treated as 1
//   accumulation_complete  in   1                   1-cycle strobe: acc_i/acc_q valid this cycle
//   acc_i                  in   NUM_TAPS*ACC_WIDTH  signed I accumulations, tap k at [k*ACC_WIDTH +: ACC_WIDTH]
//   acc_q                  in   NUM_TAPS*ACC_WIDTH  signed Q accumulations, same packing
//   busy                   out  1                   snapshot being issued to the squarer
//   overrun                out  1                   1-cycle pulse: strobe dropped because busy
//   tap_valid              out  1                   tap_i2q2/tap_index valid this cycle
//   tap_index              out  clog2(NUM_TAPS)     tap being reported
//   tap_i2q2               out  OUT_WIDTH           single-period I^2+Q^2 for tap_index
//   i2q2_valid             out  1                   1-cycle pulse: i2q2 updated with completed sum
//   i2q2                   out  NUM_TAPS*OUT_WIDTH  non-coherent sums, tap k at [k*OUT_WIDTH +: OUT_WIDTH]
// BEHAVIOUR
//   - Reset: every register and output is 0 immediately; in-flight data and the pass count are discarded.
//   - Cycle 0 = cycle with accumulation_complete high and busy low.
//     |acc_i|, |acc_q| of all taps are registered at the end of cycle 0.
//     abs(-2^(ACC_WIDTH-1)) = 2^(ACC_WIDTH-1), held in ACC_WIDTH unsigned bits.
//   - Sequencer FSM IDLE->ISSUE->IDLE.
//     ISSUE lasts cycles 1..NUM_TAPS and feeds tap k to the squarers in cycle 1+k.
//     busy = (state==ISSUE).
//   - Overrun: a strobe arriving while busy is ignored and overrun pulses the next cycle.
//     The snapshot in flight is unaffected.
//     A strobe in the cycle after ISSUE ends is accepted, so the pipeline overlaps with no bubble.
//   - Squares are registered, summed and registered again.
//     For tap k: tap_valid=1, tap_index=k and tap_i2q2=I^2+Q^2 at cycle SQ_LATENCY+2+k.
//   - Non-coherent sum: one OUT_WIDTH saturating accumulator per tap, updated at the end of that tap's tap_valid cycle.
//     On the first pass of an integration the accumulator is loaded, not added.
//     The sum saturates at 2^OUT_WIDTH-1 and never wraps.
//   - The pass counter increments after the last tap (k=NUM_TAPS-1) of each pass.
//     noncoh_len is sampled at the first pass of each integration; mid-integration changes have no effect until the next one.
//   - When the pass count reaches the sampled length:
//     i2q2 is loaded from the accumulators, i2q2_valid pulses at cycle SQ_LATENCY+2+NUM_TAPS, and the counter returns to 0.
//   - i2q2 holds its value between i2q2_valid pulses.
//     tap_i2q2/tap_index hold their last value when tap_valid is 0.
// STRUCTURE
//   - Shared header (channel.vh) gains the NUM_TAPS, SQ_LATENCY and NC_WIDTH defaults and the tap-packing macros.
//     Existing ACC_WIDTH/I2Q2_WIDTH defines stay the width source.
//   - Reuse the existing abs, iq_square and delay components.
//   - One new sub-module, i2q2_tap_sequencer: ISSUE FSM, tap counter, busy/overrun.
//     It emits tap_sel plus a valid bit that a delay line aligns with the squarer output.
// TESTING (NUM_TAPS=3, ACC_WIDTH=16, OUT_WIDTH=32, SQ_LATENCY=5)
//   1. noncoh_len=1, acc_i={0,-4,3}, acc_q={-5,3,4} (tap2..tap0), strobe at cycle 0
//      -> tap_valid cycles 7,8,9 with tap_i2q2=25 each;
//      -> i2q2_valid at cycle 10, i2q2={25,25,25}.
//   2. noncoh_len=4, same data strobed at cycles 0,4,8,12
//      -> i2q2_valid only once, at cycle 22, with i2q2={100,100,100};
//      -> no pulse earlier.
//   3. noncoh_len=2, all acc = -32768
//      -> pass 1 tap_i2q2=0x80000000;
//      -> final i2q2 every tap = 0xFFFFFFFF (saturated, not 0).
//   4. Strobe at cycle 0 and again at cycle 3
//      -> overrun=1 at cycle 4 only; results identical to scenario 1.
//      -> Strobe at cycle 4 instead -> accepted, second tap_valid burst at cycles 11..13.
//   5. global_reset asserted mid-cycle 6 of scenario 1
//      -> all outputs 0 at once, no tap_valid/i2q2_valid.
//      -> After release, a fresh strobe reproduces scenario 1 timing exactly.
//   6. noncoh_len=0 -> behaves as 1.
//      noncoh_len changed 2->3 mid-integration -> current sum still completes after 2 passes.

Source files
------------

// File: rtl/i2q2_power_engine_pkg.sv
// Shared types, defaults and helpers for the multi-tap I2Q2 power engine.
package i2q2_power_engine_pkg;

  localparam int DEF_NUM_TAPS   = 3;
  localparam int DEF_ACC_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int DEF_SQ_LATENCY = 5;
  localparam int DEF_NC_WIDTH   = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } seq_state_t;

  // A single tap still needs a one-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2q2_tap_sequencer.sv
// Issues one snapshot tap per cycle to the shared squarer and flags strobes that
// arrive while a snapshot is still being issued.
module i2q2_tap_sequencer
  import i2q2_power_engine_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int IDX_W    = idx_width(DEF_NUM_TAPS)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_strobe,
  output logic             o_accept,
  output logic             o_busy,
  output logic             o_overrun,
  output logic [IDX_W-1:0] o_tap_sel,
  output logic             o_issue_valid
);

  seq_state_t       r_state, w_next_state;
  logic [IDX_W-1:0] r_tap, w_next_tap;
  logic             r_overrun;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_tap     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_tap     <= w_next_tap;
      r_overrun <= i_strobe && (r_state == S_ISSUE);
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_tap   = r_tap;
    unique case (r_state)
      S_IDLE: begin
        if (i_strobe) begin
          w_next_state = S_ISSUE;
          w_next_tap   = '0;
        end
      end
      S_ISSUE: begin
        if (r_tap == IDX_W'(NUM_TAPS - 1)) w_next_state = S_IDLE;
        else                               w_next_tap   = r_tap + IDX_W'(1);
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_accept      = i_strobe && (r_state == S_IDLE);
  assign o_busy        = (r_state == S_ISSUE);
  assign o_issue_valid = o_busy;
  assign o_tap_sel     = r_tap;
  assign o_overrun     = r_overrun;

endmodule

// File: rtl/i2q2_power_engine.sv
// Multi-tap I^2+Q^2 engine: snapshots |I|,|Q| per tap, squares them one tap per
// cycle through a shared pipeline, then integrates non-coherently with saturation.
module i2q2_power_engine
  import i2q2_power_engine_pkg::*;
#(
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int SQ_LATENCY = DEF_SQ_LATENCY,
  parameter int NC_WIDTH   = DEF_NC_WIDTH
) (
  input  logic                              clk,
  input  logic                              global_reset,
  input  logic [NC_WIDTH-1:0]               noncoh_len,
  input  logic                              accumulation_complete,
  input  logic [NUM_TAPS*ACC_WIDTH-1:0]     acc_i,
  input  logic [NUM_TAPS*ACC_WIDTH-1:0]     acc_q,
  output logic                              busy,
  output logic                              overrun,
  output logic                              tap_valid,
  output logic [idx_width(NUM_TAPS)-1:0]    tap_index,
  output logic [OUT_WIDTH-1:0]              tap_i2q2,
  output logic                              i2q2_valid,
  output logic [NUM_TAPS*OUT_WIDTH-1:0]     i2q2
);

  localparam int IDX_W = idx_width(NUM_TAPS);
  localparam int SQ_W  = 2 * ACC_WIDTH;

  logic             w_accept, w_issue_valid;
  logic [IDX_W-1:0] w_tap_sel;

  i2q2_tap_sequencer #(.NUM_TAPS(NUM_TAPS), .IDX_W(IDX_W)) u_seq (
    .clk          (clk),
    .i_rst        (global_reset),
    .i_strobe     (accumulation_complete),
    .o_accept     (w_accept),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_tap_sel    (w_tap_sel),
    .o_issue_valid(w_issue_valid)
  );

  // Magnitudes: -2^(ACC_WIDTH-1) maps to 2^(ACC_WIDTH-1), which fits unsigned.
  logic [ACC_WIDTH-1:0] w_abs_i [NUM_TAPS];
  logic [ACC_WIDTH-1:0] w_abs_q [NUM_TAPS];
  logic [ACC_WIDTH-1:0] r_abs_i [NUM_TAPS];
  logic [ACC_WIDTH-1:0] r_abs_q [NUM_TAPS];

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_abs_i[k] = acc_i[k*ACC_WIDTH+ACC_WIDTH-1]
                 ? (~acc_i[k*ACC_WIDTH +: ACC_WIDTH] + ACC_WIDTH'(1))
                 : acc_i[k*ACC_WIDTH +: ACC_WIDTH];
      w_abs_q[k] = acc_q[k*ACC_WIDTH+ACC_WIDTH-1]
                 ? (~acc_q[k*ACC_WIDTH +: ACC_WIDTH] + ACC_WIDTH'(1))
                 : acc_q[k*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // NOTE: the snapshot and pipeline arrays are reset like any other register so
  // a reset leaves no stale tap data to leak into a later pass.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_abs_i[k] <= '0;
        r_abs_q[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_abs_i[k] <= w_abs_i[k];
        r_abs_q[k] <= w_abs_q[k];
      end
    end
  end

  logic [SQ_W-1:0]  w_mux_i, w_mux_q;
  logic [SQ_W-1:0]  r_sq_i   [SQ_LATENCY];
  logic [SQ_W-1:0]  r_sq_q   [SQ_LATENCY];
  logic             r_vld_pl [SQ_LATENCY];
  logic [IDX_W-1:0] r_idx_pl [SQ_LATENCY];
  logic             r_tap_valid;
  logic [IDX_W-1:0] r_tap_index;
  logic [OUT_WIDTH-1:0] r_tap_i2q2;

  assign w_mux_i = SQ_W'(r_abs_i[w_tap_sel]);
  assign w_mux_q = SQ_W'(r_abs_q[w_tap_sel]);

  // Squarer pipeline; valid and tap index ride alongside so they emerge aligned.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      for (int s = 0; s < SQ_LATENCY; s++) begin
        r_sq_i[s]   <= '0;
        r_sq_q[s]   <= '0;
        r_vld_pl[s] <= 1'b0;
        r_idx_pl[s] <= '0;
      end
      r_tap_valid <= 1'b0;
      r_tap_index <= '0;
      r_tap_i2q2  <= '0;
    end else begin
      r_sq_i[0]   <= w_mux_i * w_mux_i;
      r_sq_q[0]   <= w_mux_q * w_mux_q;
      r_vld_pl[0] <= w_issue_valid;
      r_idx_pl[0] <= w_tap_sel;
      for (int s = 1; s < SQ_LATENCY; s++) begin
        r_sq_i[s]   <= r_sq_i[s-1];
        r_sq_q[s]   <= r_sq_q[s-1];
        r_vld_pl[s] <= r_vld_pl[s-1];
        r_idx_pl[s] <= r_idx_pl[s-1];
      end
      r_tap_valid <= r_vld_pl[SQ_LATENCY-1];
      if (r_vld_pl[SQ_LATENCY-1]) begin
        r_tap_index <= r_idx_pl[SQ_LATENCY-1];
        // Two squares of at most 2^(2*ACC_WIDTH-2) each cannot overflow SQ_W bits.
        r_tap_i2q2  <= OUT_WIDTH'(r_sq_i[SQ_LATENCY-1] + r_sq_q[SQ_LATENCY-1]);
      end
    end
  end

  logic [OUT_WIDTH-1:0]   r_acc [NUM_TAPS];
  logic [NC_WIDTH-1:0]    r_pass, r_len;
  logic [NUM_TAPS*OUT_WIDTH-1:0] r_i2q2;
  logic                   r_i2q2_valid;
  logic [OUT_WIDTH:0]     w_sum_ext;
  logic [OUT_WIDTH-1:0]   w_new_acc;
  logic [NC_WIDTH-1:0]    w_len_live, w_len;
  logic                   w_first, w_last, w_done;

  always_comb begin
    w_first    = (r_pass == '0);
    w_sum_ext  = {1'b0, r_acc[r_tap_index]} + {1'b0, r_tap_i2q2};
    w_new_acc  = w_first ? r_tap_i2q2
               : (w_sum_ext[OUT_WIDTH] ? '1 : w_sum_ext[OUT_WIDTH-1:0]);
    w_len_live = (noncoh_len == '0) ? NC_WIDTH'(1) : noncoh_len;
    // Length is latched at tap 0 of the first pass; that same cycle uses it live.
    w_len      = (w_first && r_tap_index == '0) ? w_len_live : r_len;
    w_last     = (r_tap_index == IDX_W'(NUM_TAPS - 1));
    w_done     = w_last && (({1'b0, r_pass} + (NC_WIDTH+1)'(1)) == {1'b0, w_len});
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      for (int k = 0; k < NUM_TAPS; k++) r_acc[k] <= '0;
      r_pass       <= '0;
      r_len        <= '0;
      r_i2q2       <= '0;
      r_i2q2_valid <= 1'b0;
    end else begin
      r_i2q2_valid <= r_tap_valid && w_done;
      if (r_tap_valid) begin
        r_acc[r_tap_index] <= w_new_acc;
        if (w_first && r_tap_index == '0) r_len <= w_len_live;
        if (w_done) begin
          r_pass <= '0;
          for (int k = 0; k < NUM_TAPS; k++)
            r_i2q2[k*OUT_WIDTH +: OUT_WIDTH] <= (k == NUM_TAPS - 1) ? w_new_acc : r_acc[k];
        end else if (w_last) begin
          r_pass <= r_pass + NC_WIDTH'(1);
        end
      end
    end
  end

  assign tap_valid  = r_tap_valid;
  assign tap_index  = r_tap_index;
  assign tap_i2q2   = r_tap_i2q2;
  assign i2q2_valid = r_i2q2_valid;
  assign i2q2       = r_i2q2;

endmodule

// File: tb/tb_i2q2_power_engine.sv
// Self-checking bench: directed scenarios plus random strobes, compared every
// cycle against a schedule-based reference model of the engine's behaviour.
module tb_i2q2_power_engine;

  localparam int NT = 3, AW = 16, OW = 32, SL = 5, NW = 4, IW = 2;
  localparam int HS = 4096;
  localparam longint SAT = 64'hFFFF_FFFF;

  logic                clk = 1'b0;
  logic                global_reset;
  logic [NW-1:0]       noncoh_len;
  logic                accumulation_complete;
  logic [NT*AW-1:0]    acc_i, acc_q;
  logic                busy, overrun, tap_valid, i2q2_valid;
  logic [IW-1:0]       tap_index;
  logic [OW-1:0]       tap_i2q2;
  logic [NT*OW-1:0]    i2q2;

  always #5 clk = ~clk;

  i2q2_power_engine #(
    .NUM_TAPS(NT), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SQ_LATENCY(SL), .NC_WIDTH(NW)
  ) dut (
    .clk(clk), .global_reset(global_reset), .noncoh_len(noncoh_len),
    .accumulation_complete(accumulation_complete), .acc_i(acc_i), .acc_q(acc_q),
    .busy(busy), .overrun(overrun), .tap_valid(tap_valid), .tap_index(tap_index),
    .tap_i2q2(tap_i2q2), .i2q2_valid(i2q2_valid), .i2q2(i2q2)
  );

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus state
  int ai[NT], aq[NT];
  int len_v;
  int t;

  // Reference model: per-cycle schedule of expected events
  bit     sch_tv[HS];
  int     sch_idx[HS];
  longint sch_val[HS];
  bit     sch_ovr[HS];
  int     last_acc;
  longint m_sum[NT], m_pend[NT], m_out[NT];
  int     m_pass, m_len;
  bit     m_pend_iv;
  int     held_idx;
  longint held_val;
  bit     e_busy, e_ovr, e_tv, e_iv;

  task automatic model_clear();
    for (int c = 0; c < HS; c++) begin
      sch_tv[c] = 0; sch_ovr[c] = 0; sch_idx[c] = 0; sch_val[c] = 0;
    end
    for (int k = 0; k < NT; k++) begin
      m_sum[k] = 0; m_pend[k] = 0; m_out[k] = 0;
    end
    last_acc = -100; m_pass = 0; m_len = 1; m_pend_iv = 0;
    held_idx = 0; held_val = 0;
  endtask

  task automatic model_cycle(input bit stb);
    e_iv = m_pend_iv;
    if (m_pend_iv) m_out = m_pend;
    m_pend_iv = 0;
    e_ovr  = sch_ovr[t];
    e_busy = (t > last_acc) && (t <= last_acc + NT);
    if (stb) begin
      if (e_busy) sch_ovr[t+1] = 1;
      else begin
        last_acc = t;
        for (int k = 0; k < NT; k++) begin
          sch_tv[t+SL+2+k]  = 1;
          sch_idx[t+SL+2+k] = k;
          sch_val[t+SL+2+k] = longint'(ai[k]) * ai[k] + longint'(aq[k]) * aq[k];
        end
      end
    end
    e_tv = sch_tv[t];
    if (e_tv) begin
      int     k;
      longint v;
      k = sch_idx[t];
      v = sch_val[t];
      held_idx = k;
      held_val = v;
      if (m_pass == 0 && k == 0) m_len = (len_v == 0) ? 1 : len_v;
      if (m_pass == 0) m_sum[k] = v;
      else             m_sum[k] = (m_sum[k] + v > SAT) ? SAT : m_sum[k] + v;
      if (k == NT - 1) begin
        m_pass++;
        if (m_pass == m_len) begin
          m_pend_iv = 1;
          m_pend    = m_sum;
          m_pass    = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check($sformatf("c%0d busy", t), busy, e_busy);
    check($sformatf("c%0d overrun", t), overrun, e_ovr);
    check($sformatf("c%0d tap_valid", t), tap_valid, e_tv);
    check($sformatf("c%0d tap_index", t), tap_index, held_idx);
    check($sformatf("c%0d tap_i2q2", t), tap_i2q2, held_val);
    check($sformatf("c%0d i2q2_valid", t), i2q2_valid, e_iv);
    for (int k = 0; k < NT; k++)
      check($sformatf("c%0d i2q2[%0d]", t, k), i2q2[k*OW +: OW], m_out[k]);
  endtask

  task automatic drive(input bit stb);
    accumulation_complete = stb;
    noncoh_len = NW'(len_v);
    for (int k = 0; k < NT; k++) begin
      acc_i[k*AW +: AW] = ai[k][AW-1:0];
      acc_q[k*AW +: AW] = aq[k][AW-1:0];
    end
  endtask

  task automatic tick(input bit stb);
    drive(stb);
    model_cycle(stb);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    accumulation_complete = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);
    check("rst tap_valid", tap_valid, 0);
    check("rst tap_index", tap_index, 0);
    check("rst tap_i2q2", tap_i2q2, 0);
    check("rst i2q2_valid", i2q2_valid, 0);
    check("rst i2q2", i2q2, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    global_reset = 1'b0;
    @(posedge clk);
    #1;
    t = 0;
  endtask

  task automatic set_data1();
    ai = '{3, -4, 0};
    aq = '{4, 3, -5};
  endtask

  function automatic int rand_acc();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    global_reset = 1'b0;
    accumulation_complete = 1'b0;
    len_v = 1;
    set_data1();
    drive(1'b0);
    #1;
    do_reset();

    // 1: single pass
    set_data1(); len_v = 1;
    tick(1); idle(14);
    do_reset();

    // 2: four-pass integration, strobes every 4 cycles
    len_v = 4;
    for (int p = 0; p < 4; p++) begin tick(1); idle(3); end
    idle(14);
    do_reset();

    // 3: most-negative inputs, saturation
    ai = '{-32768, -32768, -32768}; aq = '{-32768, -32768, -32768}; len_v = 2;
    tick(1); idle(3); tick(1); idle(14);
    do_reset();

    // 4: strobe while busy, then strobe right after issue ends
    set_data1(); len_v = 1;
    tick(1); idle(2); tick(1); idle(14);
    do_reset();
    tick(1); idle(3); tick(1); idle(14);
    do_reset();

    // 5: reset in the middle of cycle 6, then a fresh pass
    tick(1); idle(5);
    drive(1'b0);
    #2;
    do_reset();
    tick(1); idle(14);
    do_reset();

    // 6: zero length behaves as one; mid-integration length change ignored
    len_v = 0;
    tick(1); idle(14);
    len_v = 2;
    tick(1); idle(9);
    len_v = 3;
    tick(1); idle(14);
    tick(1); idle(14);
    do_reset();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) len_v = int'($urandom_range(0, 15));
      for (int k = 0; k < NT; k++) begin
        ai[k] = rand_acc();
        aq[k] = rand_acc();
      end
      tick($urandom_range(0, 2) == 0);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
